// File: rtl/mem_io_pkg.sv
// Shared constants, access-type encoding and bus decode for the memory/I-O responder.
package mem_io_pkg;

   localparam logic [1:0] IO_SEL      = 2'b11;
   localparam logic [2:0] IO_RXTX_OFS = 3'd0;
   localparam logic [2:0] IO_CLK_OFS  = 3'd4;
   localparam int         RAM_BYTES   = 1 << 17;

   typedef enum logic [1:0] {
      ACC_RAM,
      ACC_RXTX,
      ACC_CLK,
      ACC_NONE
   } acc_e;

   // Offsets 4..7 all belong to the counter/stop window; 1..3 and anything above 7 are holes.
   function automatic acc_e decode(input logic [17:0] a);
      if (a[17:16] != IO_SEL) return ACC_RAM;
      if (a[15:3] != '0) return ACC_NONE;
      if (a[2:0] == IO_RXTX_OFS) return ACC_RXTX;
      if (a[2] == IO_CLK_OFS[2]) return ACC_CLK;
      return ACC_NONE;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic [7:0]             data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // Head reads as zero when empty so the output is defined straight out of reset.
   assign data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_io_responder.sv
// Far end of the CPU byte bus: 128 KB RAM plus an I/O window with RX port, buffered TX port,
// free-running cycle counter with LW-consistent snapshot, and the program-stop flag.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int    RAM_AW      = $clog2(RAM_BYTES),
   parameter int    TX_DEPTH    = 8,
   parameter int    FULL_MARGIN = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        tx_overflow,
   output logic        program_done
);

   localparam int CW = $clog2(TX_DEPTH) + 1;

   // RX and TX both use valid/ready: a byte moves on any rising edge where valid && ready,
   // valid never waits on ready, and the source holds its byte until that edge.

   logic [7:0]        ram [2**RAM_AW];
   logic [7:0]        ram_q;
   logic [7:0]        io_q;
   logic              src_ram;
   acc_e              acc;
   logic [RAM_AW-1:0] ram_idx;
   logic              unused_addr;

   logic              hold_valid;
   logic [7:0]        hold_data;
   logic [31:0]       cnt;
   logic [31:0]       snap;
   logic              halt;
   logic              stop_pending;
   logic              done_q;
   logic              buf_full_q;
   logic              overflow_q;

   logic              f_push;
   logic              f_pop;
   logic [7:0]        f_din;
   logic [7:0]        f_head;
   logic [CW-1:0]     f_count;
   logic              f_full;
   logic              f_empty;
   logic [CW-1:0]     occ_next;
   logic [CW-1:0]     free_next;

   logic              stop_req;
   logic              stop_push;
   logic              tx_wr;
   logic              byte_push;
   logic              tx_drop;

   assign acc         = decode(mem_a[17:0]);
   assign ram_idx     = mem_a[RAM_AW-1:0];
   assign unused_addr = ^mem_a[31:18];

   // A pending stop owns the push port; a CPU byte colliding with it is dropped as an overflow.
   assign stop_req  = !rst_in && !halt && (stop_pending || (acc == ACC_CLK && mem_wr));
   assign stop_push = stop_req && !f_full;
   assign tx_wr     = !rst_in && acc == ACC_RXTX && mem_wr && mem_dout != 8'h00;
   assign byte_push = tx_wr && !f_full && !stop_pending;
   assign tx_drop   = tx_wr && !byte_push;
   assign f_push    = stop_push || byte_push;
   assign f_din     = stop_push ? 8'h00 : mem_dout;
   assign f_pop     = tx_ready && !f_empty;

   assign occ_next  = f_count + CW'(f_push) - CW'(f_pop);
   assign free_next = CW'(TX_DEPTH) - occ_next;

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (f_push),
      .push_data (f_din),
      .pop       (f_pop),
      .data      (f_head),
      .count     (f_count),
      .full      (f_full),
      .empty     (f_empty)
   );

   // Read-enabled RAM port: ram_q only moves on RAM reads, which lets mem_din hold across writes.
   always_ff @(posedge clk_in) begin
      if (!rst_in && acc == ACC_RAM) begin
         if (mem_wr) ram[ram_idx] <= mem_dout;
         else        ram_q        <= ram[ram_idx];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         src_ram      <= 1'b0;
         io_q         <= 8'h00;
         hold_valid   <= 1'b0;
         hold_data    <= 8'h00;
         cnt          <= '0;
         snap         <= '0;
         halt         <= 1'b0;
         stop_pending <= 1'b0;
         done_q       <= 1'b0;
         buf_full_q   <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         cnt        <= cnt + 32'd1;
         buf_full_q <= (free_next <= CW'(FULL_MARGIN));
         done_q     <= done_q | (halt & f_empty);
         if (tx_drop) overflow_q <= 1'b1;
         if (stop_push) begin
            halt         <= 1'b1;
            stop_pending <= 1'b0;
         end else if (stop_req) begin
            stop_pending <= 1'b1;
         end
         if (rx_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= rx_data;
         end
         if (!mem_wr) begin
            src_ram <= (acc == ACC_RAM);
            case (acc)
               ACC_RXTX: begin
                  io_q <= hold_valid ? hold_data : 8'h00;
                  if (hold_valid) hold_valid <= 1'b0;
               end
               ACC_CLK: begin
                  // Offset 4 latches the whole live count so offsets 5..7 read the same instant.
                  if (mem_a[1:0] == 2'd0) begin
                     io_q <= cnt[7:0];
                     snap <= cnt;
                  end else begin
                     io_q <= snap[{mem_a[1:0], 3'b000} +: 8];
                  end
               end
               ACC_NONE: io_q <= 8'h00;
               default:  io_q <= io_q;
            endcase
         end
      end
   end

   assign mem_din        = src_ram ? ram_q : io_q;
   assign io_buffer_full = buf_full_q;
   assign rx_ready       = !hold_valid;
   assign tx_valid       = !f_empty;
   assign tx_data        = f_head;
   assign tx_overflow    = overflow_q;
   assign program_done   = done_q | (halt & f_empty);

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: queue-based reference model checked every cycle,
// a TX sink scoreboard, and hand-computed literal checks from the test plan.
module tb_mem_io_responder;

   localparam int DEPTH  = 8;
   localparam int MARGIN = 2;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] mem_a = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = '0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        tx_overflow;
   logic        program_done;

   always #5 clk_in = ~clk_in;

   mem_io_responder #(.TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .tx_overflow    (tx_overflow),
      .program_done   (program_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  m_ram [int];
   logic [7:0]  m_q [$];
   int unsigned m_cycles;
   int unsigned m_snap;
   logic        m_rx_full;
   logic [7:0]  m_rx_byte;
   logic [7:0]  m_din;
   logic        m_din_known;
   logic        m_halt, m_pend, m_ovf, m_done;
   logic        model_on = 1'b0;

   always @(posedge clk_in) begin
      logic        popped, was_full, is_io, io_ok, stop_now, rx_had;
      logic [17:0] a;
      if (rst_in) begin
         m_q.delete();
         m_cycles = 0; m_snap = 0;
         m_rx_full = 0; m_rx_byte = 0;
         m_din = 0; m_din_known = 1;
         m_halt = 0; m_pend = 0; m_ovf = 0; m_done = 0;
         model_on = 1;
      end else if (model_on) begin
         popped   = (m_q.size() != 0) && tx_ready;
         was_full = (m_q.size() == DEPTH);
         a        = mem_a[17:0];
         is_io    = (a[17:16] == 2'b11);
         io_ok    = is_io && (a[15:3] == 13'd0);
         stop_now = 0;
         rx_had   = m_rx_full;
         if (popped) void'(m_q.pop_front());
         if (!is_io) begin
            if (mem_wr) m_ram[int'(a[16:0])] = mem_dout;
            else begin
               m_din_known = m_ram.exists(int'(a[16:0]));
               if (m_din_known) m_din = m_ram[int'(a[16:0])];
            end
         end else if (!mem_wr) begin
            m_din_known = 1;
            if (io_ok && a[2:0] == 3'd0) begin
               m_din = rx_had ? m_rx_byte : 8'h00;
               m_rx_full = 0;
            end else if (io_ok && a[2]) begin
               if (a[1:0] == 2'd0) m_snap = m_cycles;
               m_din = 8'(m_snap >> (8 * a[1:0]));
            end else begin
               m_din = 8'h00;
            end
         end else begin
            if (io_ok && a[2:0] == 3'd0 && mem_dout != 8'h00) begin
               if (m_pend || was_full) m_ovf = 1;
               else m_q.push_back(mem_dout);
            end
            if (io_ok && a[2]) stop_now = 1;
         end
         if (!m_halt && (m_pend || stop_now)) begin
            if (!was_full) begin
               m_q.push_back(8'h00);
               m_halt = 1;
               m_pend = 0;
            end else begin
               m_pend = 1;
            end
         end
         if (rx_valid && !rx_had) begin
            m_rx_full = 1;
            m_rx_byte = rx_data;
         end
         m_cycles++;
         if (m_halt && m_q.size() == 0) m_done = 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_in) begin
      if (model_on) begin
         if (m_din_known) check("mdl_mem_din", 32'(mem_din), 32'(m_din));
         check("mdl_rx_ready", 32'(rx_ready), 32'(!m_rx_full));
         check("mdl_tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
         check("mdl_tx_data", 32'(tx_data), 32'((m_q.size() != 0) ? m_q[0] : 8'h00));
         check("mdl_io_buffer_full", 32'(io_buffer_full), 32'((DEPTH - m_q.size()) <= MARGIN));
         check("mdl_tx_overflow", 32'(tx_overflow), 32'(m_ovf));
         check("mdl_program_done", 32'(program_done), 32'(m_done));
      end
   end

   // ---------------- TX sink scoreboard ----------------
   logic [7:0] exp_q [$];

   always @(negedge clk_in) begin
      if (!rst_in && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected: got 0x%0h, expected no byte at %0t", tx_data, $time);
         end else begin
            check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d);
      mem_a = a; mem_wr = wr; mem_dout = d;
      @(posedge clk_in); #1;
      mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in); #1;
      end
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      for (k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk_in);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();
      @(negedge clk_in);
      check("rst_mem_din", 32'(mem_din), 32'h00);
      check("rst_io_buffer_full", 32'(io_buffer_full), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_tx_overflow", 32'(tx_overflow), 32'd0);
      check("rst_program_done", 32'(program_done), 32'd0);

      // RAM round trip; address 0 is also the idle read, so give it a known value
      access(32'h0000_0000, 1'b1, 8'h00);
      access(32'h0000_0123, 1'b1, 8'h5A);
      access(32'h0001_FFFF, 1'b1, 8'hC3);
      access(32'h0000_0123, 1'b0, 8'h00);
      @(negedge clk_in);
      check("ram_rd_00123", 32'(mem_din), 32'h5A);
      access(32'h0001_FFFF, 1'b0, 8'h00);
      @(negedge clk_in);
      check("ram_rd_1ffff", 32'(mem_din), 32'hC3);
      access(32'h0000_0050, 1'b1, 8'h77);
      @(negedge clk_in);
      check("mem_din_hold_on_wr", 32'(mem_din), 32'hC3);

      // RX path
      rx_data = 8'h41; rx_valid = 1'b1;
      idle(1);
      rx_valid = 1'b0;
      @(negedge clk_in);
      check("rx_ready_low", 32'(rx_ready), 32'd0);
      access(32'h0003_0000, 1'b0, 8'h00);
      @(negedge clk_in);
      check("rx_read_41", 32'(mem_din), 32'h41);
      check("rx_ready_back", 32'(rx_ready), 32'd1);
      access(32'h0003_0000, 1'b0, 8'h00);
      @(negedge clk_in);
      check("rx_read_empty", 32'(mem_din), 32'h00);
      rx_data = 8'h55; rx_valid = 1'b1;
      access(32'h0003_0000, 1'b0, 8'h00);
      rx_valid = 1'b0;
      @(negedge clk_in);
      check("rx_same_cycle_old", 32'(mem_din), 32'h00);
      check("rx_same_cycle_load", 32'(rx_ready), 32'd0);
      access(32'h0003_0000, 1'b0, 8'h00);
      @(negedge clk_in);
      check("rx_read_55", 32'(mem_din), 32'h55);

      // Zero byte to TX is ignored
      access(32'h0003_0000, 1'b1, 8'h00);
      @(negedge clk_in);
      check("tx_zero_ignored", 32'(tx_valid), 32'd0);
      @(negedge clk_in);
      check("tx_zero_ignored_2", 32'(tx_valid), 32'd0);

      // TX throttle and overflow
      for (int i = 1; i <= DEPTH; i++) begin
         access(32'h0003_0000, 1'b1, 8'h31);
         exp_q.push_back(8'h31);
         @(negedge clk_in);
         check("ibf_fill", 32'(io_buffer_full), 32'(i >= 6));
      end
      check("tx_full_head", 32'(tx_data), 32'h31);
      access(32'h0003_0000, 1'b1, 8'h32);
      @(negedge clk_in);
      check("tx_overflow_set", 32'(tx_overflow), 32'd1);
      @(posedge clk_in); #1 tx_ready = 1'b1;
      wait_drain("tx_drain_31", 50);
      check("tx_drained_valid", 32'(tx_valid), 32'd0);
      check("tx_drained_ibf", 32'(io_buffer_full), 32'd0);
      access(32'h0003_0000, 1'b1, 8'h61);
      exp_q.push_back(8'h61);
      wait_drain("tx_drain_61", 20);
      @(posedge clk_in); #1 tx_ready = 1'b0;

      // Counter snapshot
      do_reset();
      for (int k = 0; k < 400 && m_cycles != 32'hFF; k++) idle(1);
      access(32'h0003_0004, 1'b0, 8'h00);
      @(negedge clk_in);
      check("cnt_b0_live", 32'(mem_din), 32'hFF);
      access(32'h0003_0005, 1'b0, 8'h00);
      @(negedge clk_in);
      check("cnt_b1_snap", 32'(mem_din), 32'h00);
      access(32'h0003_0006, 1'b0, 8'h00);
      @(negedge clk_in);
      check("cnt_b2_snap", 32'(mem_din), 32'h00);
      access(32'h0003_0007, 1'b0, 8'h00);
      @(negedge clk_in);
      check("cnt_b3_snap", 32'(mem_din), 32'h00);
      access(32'h0003_0004, 1'b0, 8'h00);
      @(negedge clk_in);
      check("cnt_b0_0x103", 32'(mem_din), 32'h03);
      access(32'h0003_0005, 1'b0, 8'h00);
      @(negedge clk_in);
      check("cnt_b1_0x103", 32'(mem_din), 32'h01);
      access(32'h0003_0001, 1'b0, 8'h00);
      @(negedge clk_in);
      check("io_hole_ofs1", 32'(mem_din), 32'h00);
      access(32'h0003_0005, 1'b0, 8'h00);
      access(32'h0003_0010, 1'b0, 8'h00);
      @(negedge clk_in);
      check("io_hole_0x30010", 32'(mem_din), 32'h00);

      // Stop with a full FIFO
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         access(32'h0003_0000, 1'b1, 8'(8'h10 + i));
         exp_q.push_back(8'(8'h10 + i));
      end
      access(32'h0003_0004, 1'b1, 8'h00);
      exp_q.push_back(8'h00);
      @(negedge clk_in);
      check("stop_wait_done", 32'(program_done), 32'd0);
      check("stop_wait_head", 32'(tx_data), 32'h10);
      access(32'h0003_0005, 1'b1, 8'h00);
      @(posedge clk_in); #1 tx_ready = 1'b1;
      wait_drain("stop_drain", 60);
      for (int k = 0; k < 20 && !program_done; k++) @(negedge clk_in);
      check("stop_program_done", 32'(program_done), 32'd1);
      check("stop_tx_empty", 32'(tx_valid), 32'd0);
      access(32'h0003_0004, 1'b1, 8'h00);
      @(negedge clk_in);
      check("stop_repeat_no_push", 32'(tx_valid), 32'd0);
      check("stop_done_sticky", 32'(program_done), 32'd1);
      @(posedge clk_in); #1 tx_ready = 1'b0;

      // Reset mid-operation drops the read in flight
      rst_in = 1'b1;
      access(32'h0000_0123, 1'b0, 8'h00);
      @(negedge clk_in);
      check("rst2_program_done", 32'(program_done), 32'd0);
      check("rst2_mem_din", 32'(mem_din), 32'h00);
      rst_in = 1'b0;
      access(32'h0000_0123, 1'b0, 8'h00);
      @(negedge clk_in);
      check("ram_kept_over_rst", 32'(mem_din), 32'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected sequence completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
